expr_check_arbiter: RTL and testbench
=====================================

Name: expr_check_arbiter

Overview:
Shares the single expression-checker FSM (inputs clk, clr, in[7:0]; output out) between two character-stream requesters.
- Grants the checker to one requester per expression, round-robin.
- Clears the checker before each expression and streams characters into it.
- Samples the verdict when the terminator character arrives and returns it tagged with the requester id.

Parameters:
TERM_CHAR, 8'h3B (';'), end-of-expression character; consumed by this block, never forwarded to the checker.
MAX_LEN, 16, maximum forwarded characters per expression; exceeding it aborts the expression.

Ports:
clk  in  1  clock
clr  in  1  synchronous active-high reset
req0  in  1  requester 0 wants the checker; level, held until gnt0
req1  in  1  requester 1 wants the checker
vld0  in  1  requester 0 character valid
vld1  in  1  requester 1 character valid
in0  in  8  requester 0 ASCII character
in1  in  8  requester 1 ASCII character
gnt0  out  1  checker owned by requester 0 (CLEAR and STREAM states)
gnt1  out  1  checker owned by requester 1
rdy  out  1  STREAM state: the owner's character is consumed this cycle
chk_clr  out  1  drives the checker's clr
chk_in  out  8  drives the checker's in
chk_out  in  1  checker's out
done  out  1  one-cycle verdict strobe
done_id  out  1  requester that owns the verdict
result  out  1  1 = expression legal
err  out  1  with done: expression aborted (gap or overflow)
ok_cnt0  out  8  optional statistics, see below
ok_cnt1  out  8  optional statistics, see below

Behaviour:
- Reset (clr=1 at a clk edge):
  - state=IDLE; last-grant pointer=1, so requester 0 wins the first tie.
  - gnt0=gnt1=rdy=done=done_id=result=err=0; char count=0; ok_cnt0=ok_cnt1=0.
  - chk_clr=1 combinationally while clr=1, so the checker resets with this block.
- States: IDLE, CLEAR, STREAM, REPORT.
- IDLE:
  - If any req is high, grant the requester that is not last-grant when both request, otherwise whichever requests.
  - Latch the owner id and update last-grant. Next state = CLEAR.
- CLEAR (exactly 1 cycle): gnt of owner=1, chk_clr=1, chk_in=8'h00, rdy=0. Next state = STREAM.
- STREAM: gnt of owner=1, rdy=1, chk_clr=0. Each cycle, on the owner's inputs only:
  - vld=1, char != TERM_CHAR, count < MAX_LEN: chk_in=char; count++. Stay in STREAM.
  - vld=1, char == TERM_CHAR: chk_in=8'h00 (checker state is not sampled after this); register result = (count!=0) & chk_out, err=0. Next state = REPORT.
  - vld=0 (gap): the checker advances every clock and cannot stall, so the expression is aborted: result=0, err=1. Next state = REPORT.
  - vld=1, count == MAX_LEN, char != TERM_CHAR (overflow): result=0, err=1. Next state = REPORT.
- REPORT (1 cycle):
  - done=1, done_id=owner; result and err valid.
  - gnt0=gnt1=0, count cleared. Next state = IDLE.
- Latency from terminator accepted to done: 1 cycle.
- chk_out timing: it reflects all characters forwarded up to the previous edge, so sampling it in the terminator cycle is exact.
- Minimum turnaround between expressions: IDLE→CLEAR→STREAM means 2 dead cycles after REPORT.
- Non-owner inputs are ignored while a grant is active; the non-owner's req stays pending.
- Empty expression (terminator first) gives result=0, err=0.
- chk_in=8'h00 in every state except accepting STREAM cycles.
- Reset mid-STREAM: the expression is dropped with no done, and the checker is cleared.
- result, err and done_id hold their value until the next REPORT.

Optional Feature:
EXPR_ARB_STATS_EN
- Defined: ok_cnt0 and ok_cnt1 increment at REPORT when result=1 for the matching done_id. They saturate at 8'hFF and clear on clr.
- Undefined: the ports exist but are tied to 8'h00 and no counter flops are built.

Test Plan:
- req0 only; stream "1","+","2","*","3",";" → gnt0 for 7 cycles (CLEAR + 6 STREAM); done=1, done_id=0, result=1, err=0 one cycle after ';'.
- req1 streams "1","+","*","2",";" → done_id=1, result=0, err=0.
- req0 and req1 high in the same cycle after reset → requester 0 served first; requester 1 granted 2 cycles after requester 0's done; a third simultaneous tie goes to requester 0.
- Owner drops vld for 1 cycle after "1","+" → next cycle done=1, result=0, err=1; gnt deasserted.
- 17 non-terminator characters with MAX_LEN=16 → err=1 on the 17th; a lone ";" → result=0, err=0.
- clr pulsed mid-STREAM → no done, all outputs 0; next expression "5;" gives result=1. With EXPR_ARB_STATS_EN defined, ok_cnt0 counts 1, 2, 3 over three legal expressions from requester 0.

Source files
------------

// File: rtl/expr_check_arbiter.sv
// Round-robin arbiter that lends one external expression-checker FSM to two character-stream requesters.
// Optional per-requester legal-verdict counters are built only when EXPR_ARB_STATS_EN is defined.
module expr_check_arbiter #(
    parameter logic [7:0] TERM_CHAR = 8'h3B,
    parameter int         MAX_LEN   = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req0,
    input  logic       req1,
    input  logic       vld0,
    input  logic       vld1,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rdy,
    output logic       chk_clr,
    output logic [7:0] chk_in,
    input  logic       chk_out,
    output logic       done,
    output logic       done_id,
    output logic       result,
    output logic       err,
    output logic [7:0] ok_cnt0,
    output logic [7:0] ok_cnt1
);

    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, REPORT} state_t;

    state_t          state, state_nxt;
    logic            owner, last_gnt, pick;
    logic [CW-1:0]   count;
    logic            cur_vld, is_term, can_take, accept;
    logic [7:0]      cur_char;

    assign cur_vld  = owner ? vld1 : vld0;
    assign cur_char = owner ? in1  : in0;
    assign is_term  = (cur_char == TERM_CHAR);
    assign can_take = (count < CW'(MAX_LEN));
    assign accept   = (state == STREAM) && cur_vld && !is_term && can_take;

    // On a tie the requester that did not win last time is served.
    assign pick = (req0 && req1) ? ~last_gnt : req1;

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = CLEAR;
            CLEAR:   state_nxt = STREAM;
            // Terminator, gap and overflow all end the expression.
            STREAM:  if (!accept) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        rdy     = 1'b0;
        done    = 1'b0;
        chk_clr = clr;
        chk_in  = 8'h00;
        case (state)
            CLEAR: begin
                gnt0    = !owner;
                gnt1    = owner;
                chk_clr = 1'b1;
            end
            STREAM: begin
                gnt0   = !owner;
                gnt1   = owner;
                rdy    = 1'b1;
                chk_in = accept ? cur_char : 8'h00;
            end
            REPORT:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            count    <= '0;
            done_id  <= 1'b0;
            result   <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner    <= pick;
                        last_gnt <= pick;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        count <= count + 1'b1;
                    end else begin
                        done_id <= owner;
                        if (cur_vld && is_term) begin
                            // chk_out already reflects every forwarded character.
                            result <= (count != '0) && chk_out;
                            err    <= 1'b0;
                        end else begin
                            result <= 1'b0;
                            err    <= 1'b1;
                        end
                    end
                end
                REPORT:  count <= '0;
                default: ;
            endcase
        end
    end

`ifdef EXPR_ARB_STATS_EN
    logic [7:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt0_q <= 8'h00;
            cnt1_q <= 8'h00;
        end else if (state == REPORT && result) begin
            if (!done_id && cnt0_q != 8'hFF) cnt0_q <= cnt0_q + 8'h01;
            if (done_id  && cnt1_q != 8'hFF) cnt1_q <= cnt1_q + 8'h01;
        end
    end

    assign ok_cnt0 = cnt0_q;
    assign ok_cnt1 = cnt1_q;
`else
    assign ok_cnt0 = 8'h00;
    assign ok_cnt1 = 8'h00;
`endif

endmodule

// File: tb/tb_expr_check_arbiter.sv
// Directed bench for expr_check_arbiter with a behavioural single-digit expression checker attached.
module tb_expr_check_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic       req0, req1, vld0, vld1;
    logic [7:0] in0, in1;
    logic       gnt0, gnt1, rdy, chk_clr, chk_out, done, done_id, result, err;
    logic [7:0] chk_in, ok_cnt0, ok_cnt1;

    int errors = 0;
    int checks = 0;

    expr_check_arbiter dut (
        .clk(clk), .clr(clr), .req0(req0), .req1(req1), .vld0(vld0), .vld1(vld1),
        .in0(in0), .in1(in1), .gnt0(gnt0), .gnt1(gnt1), .rdy(rdy), .chk_clr(chk_clr),
        .chk_in(chk_in), .chk_out(chk_out), .done(done), .done_id(done_id),
        .result(result), .err(err), .ok_cnt0(ok_cnt0), .ok_cnt1(ok_cnt1)
    );

    always #5 clk = ~clk;

    // Checker: legal = digit (op digit)*. 0 expects digit, 1 after digit, 2 dead.
    logic [1:0] cst;
    always @(posedge clk) begin
        if (chk_clr) cst <= 2'd0;
        else if (chk_in != 8'h00) begin
            if (chk_in >= "0" && chk_in <= "9")
                cst <= (cst == 2'd0) ? 2'd1 : 2'd2;
            else if (chk_in == "+" || chk_in == "-" || chk_in == "*" || chk_in == "/")
                cst <= (cst == 2'd1) ? 2'd0 : 2'd2;
            else
                cst <= 2'd2;
        end
    end
    assign chk_out = (cst == 2'd1);

    typedef struct {
        int           id;
        logic [159:0] s;
        int           len;
        logic         er;
        logic         ee;
    } vec_t;

    vec_t vecs[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic gnt_of(input int id);
        return (id == 1) ? gnt1 : gnt0;
    endfunction

    task automatic drive(input int id, input logic v, input logic [7:0] c);
        if (id == 1) begin vld1 = v; in1 = c; end
        else         begin vld0 = v; in0 = c; end
    endtask

    task automatic request(input int id, input string name);
        if (id == 1) req1 = 1'b1; else req0 = 1'b1;
        for (int k = 0; k < 8 && !gnt_of(id); k++) tick;
        chk({name, ".grant"}, gnt_of(id), 1'b1);
        if (id == 1) req1 = 1'b0; else req0 = 1'b0;
    endtask

    // Entered with the owner's grant just visible (CLEAR); "_" in s means a vld gap.
    task automatic stream_expr(input int id, input logic [159:0] s, input int len,
                               input logic er, input logic ee, input string name);
        int         gcyc   = 0;
        int         bad_in = 0;
        int         early  = 0;
        logic [7:0] ch, exp_in;
        if (gnt_of(id) && !rdy) gcyc++;
        tick;
        for (int i = 0; i < len; i++) begin
            ch = s[8*(len-1-i) +: 8];
            if (gnt_of(id) && rdy) gcyc++;
            drive(id, ch != 8'h5F, ch);
            #1;
            exp_in = (ch != 8'h5F && ch != 8'h3B && i < 16) ? ch : 8'h00;
            if (chk_in !== exp_in) bad_in++;
            tick;
            if (i < len - 1 && done) early++;
        end
        drive(id, 1'b0, 8'h00);
        chk({name, ".gnt_cycles"}, gcyc, 1 + len);
        chk({name, ".chk_in"}, bad_in, 0);
        chk({name, ".early_done"}, early, 0);
        chk({name, ".done"}, done, 1'b1);
        chk({name, ".done_id"}, done_id, id[0]);
        chk({name, ".result"}, result, er);
        chk({name, ".err"}, err, ee);
        chk({name, ".gnt_off"}, {gnt0, gnt1, rdy}, 3'b000);
        tick;
        chk({name, ".done_pulse"}, done, 1'b0);
        chk({name, ".result_hold"}, {result, err}, {er, ee});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_cnt;
        vecs[0] = '{0, "1+2*3;", 6, 1'b1, 1'b0};
        vecs[1] = '{1, "1+*2;", 5, 1'b0, 1'b0};
        vecs[2] = '{0, "1+_", 3, 1'b0, 1'b1};
        vecs[3] = '{0, "1+1+1+1+1+1+1+1+1", 17, 1'b0, 1'b1};
        vecs[4] = '{1, ";", 1, 1'b0, 1'b0};
        vecs[5] = '{1, "7-3/9;", 6, 1'b1, 1'b0};
        vecs[6] = '{0, "5;", 2, 1'b1, 1'b0};

        clr = 1'b1; req0 = 0; req1 = 0; vld0 = 0; vld1 = 0; in0 = 0; in1 = 0;
        tick; tick;
        chk("reset.outs", {gnt0, gnt1, rdy, done, done_id, result, err}, 7'b0);
        chk("reset.chk_clr", chk_clr, 1'b1);
        chk("reset.chk_in", chk_in, 8'h00);
        chk("reset.ok_cnt", {ok_cnt0, ok_cnt1}, 16'h0);
        clr = 1'b0;
        tick;
        chk("idle.chk_clr", chk_clr, 1'b0);

        // Simultaneous requests: 0 first, 1 two cycles after done, next tie to 0.
        req0 = 1; req1 = 1;
        tick;
        chk("tie1.gnt", {gnt0, gnt1}, 2'b10);
        chk("tie1.chk_clr", chk_clr, 1'b1);
        req0 = 0;
        stream_expr(0, "5;", 2, 1'b1, 1'b0, "tie1.e0");
        chk("tie1.gap_gnt1", gnt1, 1'b0);
        tick;
        chk("tie1.gnt1_late", {gnt0, gnt1}, 2'b01);
        req1 = 0;
        stream_expr(1, "3;", 2, 1'b1, 1'b0, "tie1.e1");
        req0 = 1; req1 = 1;
        tick;
        chk("tie2.gnt", {gnt0, gnt1}, 2'b10);
        req0 = 0;
        stream_expr(0, "4;", 2, 1'b1, 1'b0, "tie2.e0");
        tick;
        chk("tie2.gnt1", {gnt0, gnt1}, 2'b01);
        req1 = 0;
        stream_expr(1, "8;", 2, 1'b1, 1'b0, "tie2.e1");

        for (int v = 0; v < 7; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            request(vecs[v].id, nm);
            stream_expr(vecs[v].id, vecs[v].s, vecs[v].len, vecs[v].er, vecs[v].ee, nm);
        end

        // Reset in the middle of an expression drops it silently.
        request(0, "midclr");
        tick;
        drive(0, 1'b1, "1"); tick;
        drive(0, 1'b1, "+"); tick;
        drive(0, 1'b0, 8'h00);
        clr = 1'b1;
        #1;
        chk("midclr.chk_clr", chk_clr, 1'b1);
        tick;
        chk("midclr.outs", {gnt0, gnt1, rdy, done, done_id, result, err}, 7'b0);
        clr = 1'b0;
        tick;
        chk("midclr.no_done", done, 1'b0);
        chk("midclr.ok_cnt", {ok_cnt0, ok_cnt1}, 16'h0);

        for (int k = 1; k <= 3; k++) begin
            request(0, "stats");
            stream_expr(0, "5;", 2, 1'b1, 1'b0, $sformatf("stats%0d", k));
`ifdef EXPR_ARB_STATS_EN
            exp_cnt = k;
`else
            exp_cnt = 0;
`endif
            chk($sformatf("stats%0d.ok_cnt0", k), ok_cnt0, exp_cnt[7:0]);
            chk($sformatf("stats%0d.ok_cnt1", k), ok_cnt1, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
